pellet_map_ctrl: RTL and testbench
==================================

// Module: pellet_map_ctrl
// PURPOSE
//  Owns the pellet bitmap behind the maze renderer and sequences all access to it.
//  On level_start, sweeps the maze ROM to load pellets and count them.
//  Arbitrates the single-ported map between renderer reads (xpellet/ypellet side)
//  and game-logic eat requests. Tracks pellets remaining and flags level clear.
// PARAMETERS
//  GRID_W     28  pellet columns (cells x = 0..GRID_W-1)
//  GRID_H     31  pellet rows    (cells y = 0..GRID_H-1)
//  STARVE_MAX 15  consecutive denied eat cycles before eat is forced through
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  level_start  in   1   1-cycle pulse: (re)load map from maze ROM
//  init_x       out  6   sweep column presented to maze ROM
//  init_y       out  6   sweep row presented to maze ROM
//  init_pellet  in   1   ROM answer for (init_x,init_y), combinational, same cycle
//  rd_en        in   1   renderer needs a map read this cycle
//  rd_x         in   6   renderer pellet column
//  rd_y         in   6   renderer pellet row
//  rd_pellet    out  1   pellet present at cell read last cycle (registered)
//  rd_miss      out  1   pulse: last cycle's rd_en was not served
//  eat_valid    in   1   game requests pellet clear at (eat_x,eat_y)
//  eat_x        in   6   eat column
//  eat_y        in   6   eat row
//  eat_ready    out  1   eat accepted this cycle (combinational grant)
//  eat_hit      out  1   pulse 1 cycle after accept: a pellet was removed
//  pellets_left out  10  pellets remaining
//  level_clear  out  1   all pellets eaten (RUN only)
//  busy         out  1   INIT sweep in progress
// BEHAVIOUR
//  Reset: state IDLE; map all 0; all outputs 0; starve counter 0.
//  States: IDLE -> INIT on level_start; INIT -> RUN after last cell; RUN -> INIT on level_start.
//  INIT: one cell per cycle, x fastest, from (0,0) to (GRID_W-1,GRID_H-1); GRID_W*GRID_H cycles.
//   cell <= init_pellet; pellets_left cleared on entry, +1 per set cell. busy=1.
//   rd_pellet=0, eat_ready=0, rd_miss=0 throughout. level_start in INIT restarts sweep at (0,0).
//  RUN, one map access per cycle, priority:
//   1. level_start: no access; eat_ready=0; enter INIT next cycle.
//   2. eat_valid && starve==STARVE_MAX: eat granted; rd_en denied -> rd_pellet=0, rd_miss=1 next cycle.
//   3. rd_en: read granted; rd_pellet = map[rd_y][rd_x] next cycle; eat_ready=0, starve+1 if eat_valid.
//   4. eat_valid: eat granted.
//  starve: resets to 0 on any eat grant or when eat_valid=0; saturates at STARVE_MAX.
//  Eat grant: if cell set, clear it, pellets_left-1, eat_hit=1 next cycle; else eat_hit=0.
//  Out of range (x>=GRID_W or y>=GRID_H): read returns 0; eat accepted, no change, eat_hit=0.
//  IDLE: rd_pellet=0, eat_ready=0; map untouched.
//  rd_pellet with rd_en=0 holds previous value. Latency: read 1 cycle; eat_hit 1 cycle after grant.
//  pellets_left never wraps below 0 (clear only on set cell).
//  level_clear=1 in RUN whenever pellets_left==0 (incl. a level with zero pellets); 0 in IDLE/INIT.
//  Reset asserted mid-INIT or mid-RUN: immediate return to reset state, map cleared.
// TESTING
//  Reset, level_start, ROM=1 on all cells -> busy high exactly 868 cycles, pellets_left=868, level_clear=0.
//  ROM=1 only at (1,1): rd (1,1) -> rd_pellet=1 next cycle; rd (2,1) -> 0; rd (40,1) -> 0.
//  Eat (1,1) with rd_en=0 -> eat_ready=1, eat_hit=1, pellets_left 1->0, level_clear=1; re-eat -> eat_hit=0.
//  rd_en held high, eat_valid high -> eat granted on 16th cycle, rd_miss=1 and rd_pellet=0 following cycle.
//  level_start mid-INIT at cell 300 -> init_x/init_y return to (0,0), total sweep 868 cycles from restart.
//  rst_n low mid-RUN with pellets_left=500 -> all outputs 0 asynchronously; rd any cell after RUN re-entry reflects fresh load.

Source files
------------

// File: rtl/pellet_map_ctrl.sv
// pellet_map_ctrl: owns the maze pellet bitmap. It loads the bitmap from the
// maze ROM on level_start and counts the pellets. It shares the single map
// port between renderer reads and game-logic eat requests, with a starvation
// guard for eats. It also tracks pellets remaining and reports level clear.
`timescale 1ns/1ps
module pellet_map_ctrl #(
  parameter int GRID_W     = 28,
  parameter int GRID_H     = 31,
  parameter int STARVE_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       level_start,
  output logic [5:0] init_x,
  output logic [5:0] init_y,
  input  logic       init_pellet,
  input  logic       rd_en,
  input  logic [5:0] rd_x,
  input  logic [5:0] rd_y,
  output logic       rd_pellet,
  output logic       rd_miss,
  input  logic       eat_valid,
  input  logic [5:0] eat_x,
  input  logic [5:0] eat_y,
  output logic       eat_ready,
  output logic       eat_hit,
  output logic [9:0] pellets_left,
  output logic       level_clear,
  output logic       busy
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int IDX_W = $clog2(CELLS);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [5:0]       LAST_X  = 6'(GRID_W - 1);
  localparam logic [5:0]       LAST_Y  = 6'(GRID_H - 1);
  localparam logic [STV_W-1:0] STV_SAT = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  // Cell coordinates outside the pellet grid are treated as empty, immutable cells
  function automatic logic in_grid(input logic [5:0] x, input logic [5:0] y);
    return (int'(x) < GRID_W) && (int'(y) < GRID_H);
  endfunction

  // Row-major linear index, x fastest (matches sweep order)
  function automatic logic [IDX_W-1:0] cell_idx(input logic [5:0] x, input logic [5:0] y);
    return IDX_W'(int'(y) * GRID_W + int'(x));
  endfunction

  state_t             state_q, state_d;
  logic [CELLS-1:0]   map;
  logic [5:0]         sx, sy;
  logic [STV_W-1:0]   starve;

  logic               sweep_restart;
  logic               sweep_last;
  logic               eat_gnt, rd_gnt, rd_deny;
  logic               starved;
  logic [IDX_W-1:0]   rd_idx, eat_idx, sweep_idx;
  logic               rd_val;
  logic               eat_clr;
  logic               map_we;
  logic [IDX_W-1:0]   map_widx;
  logic               map_wd;

  assign sweep_last = (sx == LAST_X) && (sy == LAST_Y);
  assign starved    = (starve == STV_SAT);
  assign rd_idx     = cell_idx(rd_x, rd_y);
  assign eat_idx    = cell_idx(eat_x, eat_y);
  assign sweep_idx  = cell_idx(sx, sy);
  assign rd_val     = in_grid(rd_x, rd_y) && map[rd_idx];
  // A grant only removes a pellet when the target cell is in the grid and set
  assign eat_clr    = eat_gnt && in_grid(eat_x, eat_y) && map[eat_idx];

  assign init_x      = sx;
  assign init_y      = sy;
  assign busy        = (state_q == INIT);
  assign eat_ready   = eat_gnt;
  assign level_clear = (state_q == RUN) && (pellets_left == 10'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and map-port arbitration (level_start > starved eat > read > eat)
  always_comb begin
    state_d       = state_q;
    sweep_restart = 1'b0;
    eat_gnt       = 1'b0;
    rd_gnt        = 1'b0;
    rd_deny       = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_start) begin
          state_d       = INIT;
          sweep_restart = 1'b1;
        end
      end
      INIT: begin
        if (level_start)     sweep_restart = 1'b1;
        else if (sweep_last) state_d       = RUN;
      end
      RUN: begin
        if (level_start) begin
          state_d       = INIT;
          sweep_restart = 1'b1;
        end else if (eat_valid && starved) begin
          eat_gnt = 1'b1;
          rd_deny = rd_en;
        end else if (rd_en) begin
          rd_gnt = 1'b1;
        end else if (eat_valid) begin
          eat_gnt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single map write port: sweep load during INIT, pellet clear on eat in RUN
  always_comb begin
    map_we   = 1'b0;
    map_widx = sweep_idx;
    map_wd   = init_pellet;
    if (state_q == INIT && !level_start) begin
      map_we = 1'b1;
    end else if (eat_clr) begin
      map_we   = 1'b1;
      map_widx = eat_idx;
      map_wd   = 1'b0;
    end
  end

  // Pellet bitmap storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      map           <= '0;
    else if (map_we) map[map_widx] <= map_wd;
  end

  // Sweep position: x fastest, wraps back to (0,0) after the last cell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx <= '0;
      sy <= '0;
    end else if (sweep_restart) begin
      sx <= '0;
      sy <= '0;
    end else if (state_q == INIT) begin
      if (sx == LAST_X) begin
        sx <= '0;
        sy <= (sy == LAST_Y) ? 6'd0 : sy + 6'd1;
      end else begin
        sx <= sx + 6'd1;
      end
    end
  end

  // Pellet count: rebuilt during the sweep, decremented only on a real removal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pellets_left <= '0;
    else if (sweep_restart)
      pellets_left <= '0;
    else if (state_q == INIT && init_pellet)
      pellets_left <= pellets_left + 10'd1;
    else if (eat_clr && pellets_left != 10'd0)
      pellets_left <= pellets_left - 10'd1;
  end

  // Starvation counter: counts consecutive cycles an eat request lost to a read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve <= '0;
    else if (state_q != RUN || !eat_valid || eat_gnt)
      starve <= '0;
    else if (rd_gnt && !starved)
      starve <= starve + 1'b1;
  end

  // Read data, miss and hit pulses; read data holds when no read is serviced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pellet <= 1'b0;
      rd_miss   <= 1'b0;
      eat_hit   <= 1'b0;
    end else begin
      rd_miss <= rd_deny;
      eat_hit <= eat_clr;
      if (state_q != RUN || level_start) rd_pellet <= 1'b0;
      else if (rd_deny)                  rd_pellet <= 1'b0;
      else if (rd_gnt)                   rd_pellet <= rd_val;
    end
  end

endmodule

// File: tb/tb_pellet_map_ctrl.sv
// Directed bench for pellet_map_ctrl: vector tables for RUN-phase accesses
// plus hand sequences for load sweep, restart, starvation and async reset.
`timescale 1ns/1ps
module tb_pellet_map_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       level_start;
  logic [5:0] init_x, init_y;
  logic       init_pellet;
  logic       rd_en;
  logic [5:0] rd_x, rd_y;
  logic       rd_pellet, rd_miss;
  logic       eat_valid;
  logic [5:0] eat_x, eat_y;
  logic       eat_ready, eat_hit;
  logic [9:0] pellets_left;
  logic       level_clear, busy;
  logic       rom_all;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Maze ROM model: every cell set, or only cell (1,1)
  assign init_pellet = rom_all ? 1'b1 : (init_x == 6'd1 && init_y == 6'd1);

  pellet_map_ctrl #(.GRID_W(28), .GRID_H(31), .STARVE_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .level_start(level_start),
    .init_x(init_x), .init_y(init_y), .init_pellet(init_pellet),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_pellet(rd_pellet), .rd_miss(rd_miss),
    .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y),
    .eat_ready(eat_ready), .eat_hit(eat_hit),
    .pellets_left(pellets_left), .level_clear(level_clear), .busy(busy)
  );

  typedef struct {
    logic       rd_en;
    logic [5:0] rd_x, rd_y;
    logic       eat_valid;
    logic [5:0] eat_x, eat_y;
    logic       exp_ready;
    logic       exp_rd;
    logic       exp_miss;
    logic       exp_hit;
    int         exp_left;
    logic       exp_clear;
  } vec_t;

  vec_t tbl_a[11];
  vec_t tbl_b[4];

  function automatic vec_t mkv(input logic re, input int rx, input int ry,
                               input logic ev, input int ex, input int ey,
                               input logic rdy, input logic rp, input logic ms,
                               input logic ht, input int lf, input logic cl);
    vec_t v;
    v.rd_en = re; v.rd_x = 6'(rx); v.rd_y = 6'(ry);
    v.eat_valid = ev; v.eat_x = 6'(ex); v.eat_y = 6'(ey);
    v.exp_ready = rdy; v.exp_rd = rp; v.exp_miss = ms; v.exp_hit = ht;
    v.exp_left = lf; v.exp_clear = cl;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic apply_vec(input vec_t v, input string tag, input int id);
    rd_en = v.rd_en; rd_x = v.rd_x; rd_y = v.rd_y;
    eat_valid = v.eat_valid; eat_x = v.eat_x; eat_y = v.eat_y;
    #1;
    chk($sformatf("%s%0d_eat_ready", tag, id), int'(eat_ready), int'(v.exp_ready));
    @(negedge clk);
    chk($sformatf("%s%0d_rd_pellet", tag, id), int'(rd_pellet), int'(v.exp_rd));
    chk($sformatf("%s%0d_rd_miss", tag, id), int'(rd_miss), int'(v.exp_miss));
    chk($sformatf("%s%0d_eat_hit", tag, id), int'(eat_hit), int'(v.exp_hit));
    chk($sformatf("%s%0d_left", tag, id), int'(pellets_left), v.exp_left);
    chk($sformatf("%s%0d_clear", tag, id), int'(level_clear), int'(v.exp_clear));
    rd_en = 1'b0; eat_valid = 1'b0;
  endtask

  // Counts negedges with busy high, starting at the current one
  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    level_start = 1'b1;
    @(negedge clk);
    level_start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_rd_pellet"}, int'(rd_pellet), 0);
    chk({tag, "_rd_miss"}, int'(rd_miss), 0);
    chk({tag, "_eat_ready"}, int'(eat_ready), 0);
    chk({tag, "_eat_hit"}, int'(eat_hit), 0);
    chk({tag, "_left"}, int'(pellets_left), 0);
    chk({tag, "_clear"}, int'(level_clear), 0);
    chk({tag, "_init_x"}, int'(init_x), 0);
    chk({tag, "_init_y"}, int'(init_y), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g;
    // Map holds only (1,1)
    tbl_a[0]  = mkv(1, 1, 1, 0, 0, 0,   0, 1, 0, 0, 1, 0);
    tbl_a[1]  = mkv(1, 2, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0);
    tbl_a[2]  = mkv(1, 40, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    tbl_a[3]  = mkv(1, 1, 1, 0, 0, 0,   0, 1, 0, 0, 1, 0);
    tbl_a[4]  = mkv(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0);
    tbl_a[5]  = mkv(0, 0, 0, 1, 1, 1,   1, 1, 0, 1, 0, 1);
    tbl_a[6]  = mkv(0, 0, 0, 1, 1, 1,   1, 1, 0, 0, 0, 1);
    tbl_a[7]  = mkv(1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    tbl_a[8]  = mkv(0, 0, 0, 1, 40, 3,  1, 0, 0, 0, 0, 1);
    tbl_a[9]  = mkv(1, 1, 1, 1, 2, 2,   0, 0, 0, 0, 0, 1);
    tbl_a[10] = mkv(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    // Fresh single-pellet load after reset
    tbl_b[0]  = mkv(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
    tbl_b[1]  = mkv(1, 1, 1, 0, 0, 0,   0, 1, 0, 0, 1, 0);
    tbl_b[2]  = mkv(1, 3, 3, 0, 0, 0,   0, 0, 0, 0, 1, 0);
    tbl_b[3]  = mkv(0, 0, 0, 1, 1, 1,   1, 0, 0, 1, 0, 1);

    rst_n = 1'b0; level_start = 1'b0; rom_all = 1'b1;
    rd_en = 1'b0; rd_x = '0; rd_y = '0;
    eat_valid = 1'b0; eat_x = '0; eat_y = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE ignores eats
    eat_valid = 1'b1; eat_x = 6'd1; eat_y = 6'd1;
    #1 chk("idle_eat_ready", int'(eat_ready), 0);
    eat_valid = 1'b0;
    @(negedge clk);

    // Full load, every cell set
    pulse_start();
    chk("init_start_x", int'(init_x), 0);
    chk("init_start_y", int'(init_y), 0);
    chk("init_busy", int'(busy), 1);
    chk("init_clear", int'(level_clear), 0);
    eat_valid = 1'b1;
    #1 chk("init_eat_ready", int'(eat_ready), 0);
    eat_valid = 1'b0;
    wait_sweep(n);
    chk("all_busy_cycles", n, 868);
    chk("all_left", int'(pellets_left), 868);
    chk("all_clear", int'(level_clear), 0);

    // Single-pellet load, restarted at cell 300
    rom_all = 1'b0;
    pulse_start();
    for (int k = 0; k < 1000; k++) begin
      if (int'(init_y) * 28 + int'(init_x) == 300) break;
      @(negedge clk);
    end
    chk("restart_reached_300", int'(init_y) * 28 + int'(init_x), 300);
    pulse_start();
    chk("restart_x", int'(init_x), 0);
    chk("restart_y", int'(init_y), 0);
    chk("restart_left", int'(pellets_left), 0);
    wait_sweep(n);
    chk("restart_busy_cycles", n, 868);
    chk("single_left", int'(pellets_left), 1);
    chk("single_clear", int'(level_clear), 0);

    for (int i = 0; i < 11; i++) apply_vec(tbl_a[i], "a", i);

    // Reload all ones, then hold read and eat together to exercise starvation
    rom_all = 1'b1;
    pulse_start();
    wait_sweep(n);
    chk("reload_busy_cycles", n, 868);
    chk("reload_left", int'(pellets_left), 868);
    rd_en = 1'b1; rd_x = 6'd0; rd_y = 6'd0;
    eat_valid = 1'b1; eat_x = 6'd3; eat_y = 6'd3;
    g = 0;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (k == 2) chk("starve_rd_before", int'(rd_pellet), 1);
      if (eat_ready) begin
        g = k;
        break;
      end
      @(negedge clk);
    end
    chk("starve_grant_cycle", g, 16);
    @(negedge clk);
    chk("starve_rd_miss", int'(rd_miss), 1);
    chk("starve_rd_pellet", int'(rd_pellet), 0);
    chk("starve_eat_hit", int'(eat_hit), 1);
    chk("starve_left", int'(pellets_left), 867);
    #1 chk("starve_reset_ready", int'(eat_ready), 0);
    rd_en = 1'b0; eat_valid = 1'b0;
    @(negedge clk);
    chk("starve_miss_pulse", int'(rd_miss), 0);

    // Eat 367 further cells down to 500 remaining
    for (int i = 100; i <= 466; i++) begin
      eat_valid = 1'b1; eat_x = 6'(i % 28); eat_y = 6'(i / 28);
      @(negedge clk);
    end
    eat_valid = 1'b0;
    chk("eatdown_left", int'(pellets_left), 500);
    chk("eatdown_hit", int'(eat_hit), 1);

    // Asynchronous reset mid-RUN
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    rom_all = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_sweep(n);
    chk("fresh_busy_cycles", n, 868);
    for (int i = 0; i < 4; i++) apply_vec(tbl_b[i], "b", i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
